// File: rtl/sr_ff_driver.sv
// Purpose  : command-side driver for a bank of N SR flip-flops. Pulses s/r only on
//            bits that differ from the fed-back q, waits SETTLE cycles, verifies
//            the readback, retries up to RETRIES times, then reports done/err.
// Latency  : done arrives SETTLE+3 cycles after acceptance on a first-attempt pass.
//            Each retry adds SETTLE+2 cycles. Worst case is
//            (RETRIES+1)*(SETTLE+2)+1 cycles. An already-matching target
//            completes in 1 cycle.
// Backpress: req is sampled only while idle (busy=0). Requests arriving while
//            busy are dropped, not queued. The done cycle is idle, so a req
//            presented there is accepted.
//
// Ports:
//   clk     - single clock, rising edge
//   reset   - synchronous active-high reset; aborts any transaction, no done
//   req     - request strobe, sampled only in IDLE
//   target  - desired flip-flop word, captured on acceptance
//   q_fb    - q outputs of the driven flip-flops
//   s, r    - registered one-cycle set/reset pulses (never both high on a bit)
//   busy    - high from the cycle after acceptance until done
//   done    - one-cycle completion pulse
//   err     - verify failure, valid with done, held until the next acceptance
//   shadow  - last accepted target that completed with err=0
module sr_ff_driver #(
  parameter int N       = 8,
  parameter int SETTLE  = 2,
  parameter int RETRIES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [N-1:0] target,
  input  logic [N-1:0] q_fb,
  output logic [N-1:0] s,
  output logic [N-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] shadow
);

  // The settle counter loads SETTLE-1 and counts down to 0, so it only has to
  // hold SETTLE-1. The attempt counter has to hold RETRIES.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int ATT_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE - 1);
  localparam logic [ATT_W-1:0] ATT_LIMIT = ATT_W'(RETRIES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  state_t             state_q;
  logic [N-1:0]       tgt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ATT_W-1:0]   att_q;
  logic [N-1:0]       s_q;
  logic [N-1:0]       r_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [N-1:0]       shadow_q;

  // Reference word for the mask computation. In IDLE it is the incoming
  // target, because the masks for the first pulse are formed on the
  // acceptance edge. After that it is the captured target, so later changes
  // on target cannot leak into a retry.
  logic [N-1:0] ref_w;
  logic [N-1:0] set_d;
  logic [N-1:0] rst_d;
  logic         match_w;
  logic         retry_ok_w;

  always_comb begin
    ref_w      = (state_q == ST_IDLE) ? target : tgt_q;
    // The two masks are disjoint by construction: a bit is either
    // (ref=1, q=0) or (ref=0, q=1), never both. So s & r is always 0.
    set_d      = ref_w & ~q_fb;
    rst_d      = ~ref_w & q_fb;
    match_w    = ((set_d | rst_d) == '0);
    retry_ok_w = (att_q < ATT_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tgt_q    <= '0;
      cnt_q    <= '0;
      att_q    <= '0;
      s_q      <= '0;
      r_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      // Pulses and done are single-cycle. They default low and are raised
      // only on the edge that starts them.
      s_q    <= '0;
      r_q    <= '0;
      done_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            tgt_q <= target;
            att_q <= '0;
            err_q <= 1'b0;
            if (match_w) begin
              // Nothing to change: complete immediately without going busy.
              done_q   <= 1'b1;
              shadow_q <= target;
            end else begin
              s_q     <= set_d;
              r_q     <= rst_d;
              busy_q  <= 1'b1;
              state_q <= ST_DRIVE;
            end
          end
        end

        ST_DRIVE: begin
          // The pulse is visible during this cycle. Start the settle window next.
          cnt_q   <= CNT_LOAD;
          state_q <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_CHECK: begin
          if (match_w) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            shadow_q <= tgt_q;
            state_q  <= ST_IDLE;
          end else if (retry_ok_w) begin
            // Re-derive the masks from the present readback, so a retry
            // touches only the bits that are still wrong.
            s_q     <= set_d;
            r_q     <= rst_d;
            att_q   <= att_q + ATT_W'(1);
            state_q <= ST_DRIVE;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s      = s_q;
  assign r      = r_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign shadow = shadow_q;

endmodule

// File: doc/sr_ff_driver.md
# sr_ff_driver

Command-side driver for a bank of N `SR_ff` flip-flops. It accepts a target word over a req/busy/done handshake. It issues single-cycle set and reset pulses only on bits that differ from the flip-flops' fed-back `q`, waits a settle interval, and verifies the readback. It retries a bounded number of times, then reports `done` with pass/fail. It never presents the illegal s=r=1 code to any flip-flop.

## Interface
- `N`, 8, number of SR flip-flop channels driven.
- `SETTLE`, 2, idle cycles (s=r=0) between the pulse and the readback check; legal range is 1 or more.
- `RETRIES`, 1, additional drive attempts after a failed check; legal range is 0 or more.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  request; sampled only in IDLE.
- `target`  in  N  desired flip-flop state; captured on acceptance.
- `q_fb`  in  N  `q` outputs of the driven flip-flops.
- `s`  out  N  registered set pulses to the flip-flops.
- `r`  out  N  registered reset pulses to the flip-flops.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  verify-failure flag; valid with `done`, held until the next acceptance.
- `shadow`  out  N  last target accepted that completed with err=0.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK.
- **Acceptance (IDLE):** an edge with req=1 is the acceptance edge.
  - Captures `tgt_reg`=`target`.
  - Computes `set_m` = `target & ~q_fb` and `rst_m` = `~target & q_fb` from `q_fb` at that edge.
  - Clears the attempt counter and `err`.
- **No work:** if `set_m`=`rst_m`=0, go to IDLE with done=1 and err=0 next cycle. `shadow` updates, busy stays 0, and no s/r pulse is issued.
- **Work:** otherwise go to DRIVE. In DRIVE, s=`set_m` and r=`rst_m` for exactly one cycle.
- **SETTLE:** after DRIVE, the block sits in SETTLE for `SETTLE` cycles with s=r=0 and a down-counter running.
- **CHECK:** one cycle. Compare `q_fb` against `tgt_reg`.
  - Equal: go to IDLE; done=1 and err=0 next cycle; `shadow`=`tgt_reg`.
  - Unequal and attempts < `RETRIES`: recompute the masks from the current `q_fb` against `tgt_reg`, increment attempts, and go to DRIVE.
  - Unequal and attempts = `RETRIES`: go to IDLE; done=1 and err=1 next cycle; `shadow` unchanged.
- **Invariant:** `s & r` = 0 on every cycle, because the masks are disjoint by construction.
- **Ignored inputs:**
  - `req` while not in IDLE; requests are not queued.
  - `target` changes after acceptance.
- **Back-to-back:** the cycle in which done=1 is an IDLE cycle, so a req there is accepted.

## Timing
- **Reset values:** s=0, r=0, busy=0, done=0, err=0, shadow=0. State=IDLE; `tgt_reg`, masks and counters are 0.
- **Reset mid-operation:** reset wins over every other event on the same edge. It aborts the transaction and returns all outputs to reset values on the next cycle. No done is generated, and any pulse in flight is dropped.
- **Cycle numbering:** cycle 0 is the cycle before the acceptance edge.
- **Successful first attempt:**
  - s/r asserted in cycle 1.
  - Settle in cycles 2..SETTLE+1.
  - CHECK in cycle SETTLE+2.
  - done in cycle SETTLE+3.
  - busy=1 in cycles 1..SETTLE+2.
- **Each retry** adds SETTLE+2 cycles.
- **Worst-case latency:** (RETRIES+1)·(SETTLE+2)+1 cycles.
- `done` and `busy` are never high together.

## Test plan
- **Reset:** hold reset 3 cycles with req=1 and target=FF -> all outputs 0; no s/r activity.
- **Normal write:** N=8, SETTLE=2, q_fb=0x0F, target=0x3C, model responds to s/r next edge -> s=0x30 and r=0x03 in cycle 1; done=1 and err=0 in cycle 5; shadow=0x3C.
- **No change:** q_fb=target=0xA5 -> done in cycle 1, err=0, s=r=0 throughout, busy never 1.
- **Stuck bit:** bit 2 of q_fb stuck at 0, target=0x04, RETRIES=1 -> two s=0x04 pulses 4 cycles apart; done=1 and err=1 in cycle 9; shadow unchanged.
- **Reset mid-operation:** assert reset during SETTLE -> outputs return to reset values next cycle; no done pulse. req one cycle after reset release is accepted normally.
- **Ignored/back-to-back requests:** req held high with target changing every cycle while busy -> only the first target is driven. Random regression checks `s & r` = 0 on every cycle, and that a new req in the done cycle is accepted.
